sobel_edge_detect: RTL and testbench



---
 rtl/sobel_pkg.sv | 52 +++++
 rtl/sobel_edge_detect_line_buf.sv | 23 ++
 rtl/sobel_edge_detect.sv | 189 ++++++++++++++++++
 tb/tb_sobel_edge_detect.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared widths, constants and helpers for the Sobel edge pipeline.
// Kernel weights, gradient helpers and the output mode enum live here.
package sobel_pkg;

  localparam int MAG_W    = 11;
  localparam int GRAD_W   = 11;
  localparam int ROW_W    = 11;
  localparam int PIPE_LAT = 3;

  localparam logic [7:0] THR_RST = 8'd50;

  localparam logic [GRAD_W-2:0] KW_EDGE = 10'd1;
  localparam logic [GRAD_W-2:0] KW_MID  = 10'd2;

  typedef enum logic {
    EDGE = 1'b0,
    GRAY = 1'b1
  } mode_e;

  typedef struct packed {
    logic       vld;
    logic       ok;
    logic [7:0] gray;
  } meta_t;

  // Weighted sum of one kernel column or row: a + 2b + c.
  function automatic logic [GRAD_W-2:0] tap3(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return KW_EDGE * {2'b00, a}
         + KW_MID  * {2'b00, b}
         + KW_EDGE * {2'b00, c};
  endfunction

  // Signed difference of two weighted sums; never wraps.
  function automatic logic signed [GRAD_W-1:0] grad(
    input logic [GRAD_W-2:0] pos,
    input logic [GRAD_W-2:0] neg
  );
    return $signed({1'b0, pos}) - $signed({1'b0, neg});
  endfunction

  // Absolute value of a gradient; range is at most 1020.
  function automatic logic [MAG_W-1:0] absv(
    input logic signed [GRAD_W-1:0] g
  );
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

endpackage

// File: rtl/sobel_edge_detect_line_buf.sv
// Single-line pixel delay: read-before-write RAM addressed by column.
// The read port is asynchronous so the old line is seen on the same beat.
module line_buf #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [DEPTH];

  assign dout = mem[addr];

  // Overwrite the entry after its previous-line value was read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_edge_detect.sv
// 3x3 Sobel L1 magnitude with threshold/gray select, 3-cycle pipeline.
// Define SOBEL_GRAY_MAG_EN for graded magnitude output instead of binary.
module sobel_edge_detect
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640
) (
  input  logic       pclk,
  input  logic       s_rst,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] gray_i,
  input  logic [7:0] yuzhi,
  input  logic       ch_select,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] pix_o
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int AW = $clog2(IMG_W);

  logic [CW-1:0]    col_q;
  logic [CW-1:0]    cur_col;
  logic [ROW_W-1:0] row_q;
  logic             href_q;
  logic             vsync_q;
  logic [7:0]       thr_q;
  mode_e            sel_q;
  logic             frame_ok;

  logic          line_start;
  logic          beat_ok;
  logic          win_ok;
  logic [AW-1:0] addr;
  logic [7:0]    lb0_q;
  logic [7:0]    lb1_q;

  logic [7:0] p [3][3];

  logic [PIPE_LAT-1:0] vs_d;
  logic [PIPE_LAT-1:0] hr_d;

  meta_t s1;
  meta_t s2;

  logic signed [GRAD_W-1:0] gx_c;
  logic signed [GRAD_W-1:0] gy_c;
  logic signed [GRAD_W-1:0] gx2;
  logic signed [GRAD_W-1:0] gy2;

  logic [MAG_W-1:0] mag;
  logic             hit;
  logic [7:0]       edge_pix;
  logic [7:0]       res;

  assign line_start = href_i & ~href_q;
  assign cur_col    = line_start ? '0 : col_q;
  assign beat_ok    = href_i & ~vsync_i
                    & (cur_col < CW'(IMG_W));
  assign win_ok     = beat_ok
                    & (row_q >= ROW_W'(2))
                    & (cur_col >= CW'(2));
  assign addr       = beat_ok ? AW'(cur_col) : '0;

  line_buf #(.DEPTH(IMG_W)) lb0 (
    .clk  (pclk),
    .we   (beat_ok),
    .addr (addr),
    .din  (gray_i),
    .dout (lb0_q)
  );

  line_buf #(.DEPTH(IMG_W)) lb1 (
    .clk  (pclk),
    .we   (beat_ok),
    .addr (addr),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  // Frame controls, edge detectors and column/row counters.
  always_ff @(posedge pclk or posedge s_rst) begin
    if (s_rst) begin
      thr_q    <= THR_RST;
      sel_q    <= EDGE;
      frame_ok <= 1'b0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
      if (vsync_i & ~vsync_q) begin
        thr_q    <= yuzhi;
        sel_q    <= ch_select ? GRAY : EDGE;
        frame_ok <= 1'b1;
      end
      if (vsync_i) begin
        row_q <= '0;
      end else if (href_q & ~href_i
                   & (row_q != {ROW_W{1'b1}})) begin
        row_q <= row_q + 1'b1;
      end
      if (href_i & ~vsync_i) begin
        col_q <= (cur_col == CW'(IMG_W))
               ? cur_col : cur_col + 1'b1;
      end
    end
  end

  // S1: shift the new column into the 3x3 window.
  always_ff @(posedge pclk or posedge s_rst) begin
    if (s_rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          p[r][c] <= '0;
        end
      end
      s1 <= '0;
    end else begin
      if (beat_ok) begin
        for (int r = 0; r < 3; r++) begin
          p[r][0] <= p[r][1];
          p[r][1] <= p[r][2];
        end
        p[0][2] <= lb1_q;
        p[1][2] <= lb0_q;
        p[2][2] <= gray_i;
      end
      s1.vld  <= beat_ok;
      s1.ok   <= win_ok;
      s1.gray <= gray_i;
    end
  end

  assign gx_c = grad(tap3(p[0][2], p[1][2], p[2][2]),
                     tap3(p[0][0], p[1][0], p[2][0]));
  assign gy_c = grad(tap3(p[2][0], p[2][1], p[2][2]),
                     tap3(p[0][0], p[0][1], p[0][2]));

  // S2: register the two gradients.
  always_ff @(posedge pclk or posedge s_rst) begin
    if (s_rst) begin
      gx2 <= '0;
      gy2 <= '0;
      s2  <= '0;
    end else begin
      gx2 <= gx_c;
      gy2 <= gy_c;
      s2  <= s1;
    end
  end

  // S3 datapath: magnitude, threshold and output select.
  always_comb begin
    mag      = absv(gx2) + absv(gy2);
    hit      = mag > {{(MAG_W-8){1'b0}}, thr_q};
    edge_pix = 8'h00;
    res      = 8'h00;
`ifdef SOBEL_GRAY_MAG_EN
    if (hit) edge_pix = (mag > MAG_W'(255)) ? 8'hFF : mag[7:0];
`else
    if (hit) edge_pix = 8'hFF;
`endif
    if (frame_ok && s2.vld) begin
      if (sel_q == GRAY) res = s2.gray;
      else if (s2.ok)    res = edge_pix;
    end
  end

  // S3 register plus sync delay lines matched to the datapath.
  always_ff @(posedge pclk or posedge s_rst) begin
    if (s_rst) begin
      vs_d  <= '0;
      hr_d  <= '0;
      pix_o <= '0;
    end else begin
      vs_d  <= {vs_d[PIPE_LAT-2:0], vsync_i};
      hr_d  <= {hr_d[PIPE_LAT-2:0], href_i};
      pix_o <= res;
    end
  end

  assign vsync_o = vs_d[PIPE_LAT-1];
  assign href_o  = hr_d[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect with hand-derived edge maps.
// Images are column- or row-only patterns so expected maps stay simple.
module tb_sobel_edge_detect;

  localparam int W = 640;

  logic       pclk = 1'b0;
  logic       s_rst = 1'b1;
  logic       vsync_i = 1'b0;
  logic       href_i = 1'b0;
  logic [7:0] gray_i = 8'd0;
  logic [7:0] yuzhi = 8'd0;
  logic       ch_select = 1'b0;
  logic       vsync_o;
  logic       href_o;
  logic [7:0] pix_o;

  int total = 0;
  int bad = 0;

  int sync_bad = 0;
  int nz_gate = 0;
  bit gate_chk = 1'b0;
  int beats = 0;
  logic [9:0] rst_obs = '0;

  logic [7:0] img [0:7][0:W-1];

  sobel_edge_detect #(.IMG_W(W)) dut (
    .pclk      (pclk),
    .s_rst     (s_rst),
    .vsync_i   (vsync_i),
    .href_i    (href_i),
    .gray_i    (gray_i),
    .yuzhi     (yuzhi),
    .ch_select (ch_select),
    .vsync_o   (vsync_o),
    .href_o    (href_o),
    .pix_o     (pix_o)
  );

  initial forever #5 pclk = ~pclk;

  // Output monitor: sync alignment, gating and frame capture.
  initial begin
    logic h1, h2, h3, v1, v2, v3, hprev;
    int orow, ocol;
    h1 = 0; h2 = 0; h3 = 0;
    v1 = 0; v2 = 0; v3 = 0;
    hprev = 0; orow = 0; ocol = 0;
    forever begin
      @(negedge pclk);
      if (s_rst) begin
        h1 = 0; h2 = 0; h3 = 0;
        v1 = 0; v2 = 0; v3 = 0;
        hprev = 0; orow = 0; ocol = 0;
      end else begin
        if (href_o !== h3 || vsync_o !== v3) sync_bad++;
        if (!href_o && pix_o !== 8'd0) sync_bad++;
        if ($isunknown(pix_o)) sync_bad++;
        if (gate_chk && pix_o !== 8'd0) nz_gate++;
        if (vsync_o) begin
          orow = 0; ocol = 0;
        end else if (href_o) begin
          if (orow < 8 && ocol < W) img[orow][ocol] = pix_o;
          ocol++;
          beats++;
        end else if (hprev) begin
          orow++;
          ocol = 0;
        end
        hprev = href_o;
        h3 = h2; h2 = h1; h1 = href_i;
        v3 = v2; v2 = v1; v1 = vsync_i;
      end
    end
  end

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0: return 8'd100;
      1: return (c < 8) ? 8'd0 : 8'd200;
      2: return (c < 8) ? 8'd0 : 8'd10;
      3: return (r < 2) ? 8'd0 : 8'd200;
      default: return 8'((r * 37 + c * 3) & 255);
    endcase
  endfunction

  function automatic logic [7:0] val(input int mag, input logic [7:0] thr);
    if (mag <= int'(thr)) return 8'd0;
`ifdef SOBEL_GRAY_MAG_EN
    return (mag > 255) ? 8'd255 : 8'(mag);
`else
    return 8'hFF;
`endif
  endfunction

  // Output beat (r,c) shows the centre (r-1,c-1); magnitudes by hand.
  function automatic logic [7:0] expv(input int pat, input int r, input int c,
                                      input logic [7:0] thr, input bit gray);
    if (gray) return pix(pat, r, c);
    case (pat)
      1: return (r >= 2 && (c == 8 || c == 9)) ? val(800, thr) : 8'd0;
      2: return (r >= 2 && (c == 8 || c == 9)) ? val(40, thr) : 8'd0;
      3: return ((r == 2 || r == 3) && c >= 2) ? val(800, thr) : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  function automatic int row_bad(input int pat, input int r, input int len,
                                 input logic [7:0] thr, input bit gray,
                                 output int fc, output logic [7:0] fa,
                                 output logic [7:0] fe);
    int n;
    n = 0; fc = -1; fa = 0; fe = 0;
    for (int c = 0; c < len; c++) begin
      if (img[r][c] !== expv(pat, r, c, thr, gray)) begin
        if (n == 0) begin
          fc = c; fa = img[r][c]; fe = expv(pat, r, c, thr, gray);
        end
        n++;
      end
    end
    return n;
  endfunction

  task automatic step(input logic v, input logic h, input logic [7:0] g);
    @(posedge pclk); #1;
    vsync_i = v; href_i = h; gray_i = g;
  endtask

  task automatic drive_frame(input int pat, input int nrows, input bit with_vs,
                             input logic [7:0] yz, input logic ch,
                             input logic [7:0] yz_mid, input logic ch_mid,
                             input int short_row, input int rst_row,
                             input int rst_col);
    beats = 0;
    yuzhi = yz;
    ch_select = ch;
    if (with_vs) repeat (3) step(1'b1, 1'b0, 8'd0);
    repeat (5) step(1'b0, 1'b0, 8'd0);
    for (int r = 0; r < nrows; r++) begin
      int len;
      len = (r == short_row) ? 300 : W;
      if (r == 2) begin
        yuzhi = yz_mid;
        ch_select = ch_mid;
      end
      for (int c = 0; c < len; c++) begin
        step(1'b0, 1'b1, pix(pat, r, c));
        if (s_rst) s_rst = 1'b0;
        if (r == rst_row && c == rst_col) begin
          s_rst = 1'b1;
          #1;
          rst_obs = {vsync_o, href_o, pix_o};
          gate_chk = 1'b1;
        end
      end
      repeat (10) step(1'b0, 1'b0, 8'd0);
    end
    repeat (8) step(1'b0, 1'b0, 8'd0);
    s_rst = 1'b0;
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    total++;
    if (vsync_o !== 1'b0) begin
      bad++; $display("FAIL reset_vsync got %b want 0", vsync_o);
    end
    total++;
    if (href_o !== 1'b0) begin
      bad++; $display("FAIL reset_href got %b want 0", href_o);
    end
    total++;
    if (pix_o !== 8'd0) begin
      bad++; $display("FAIL reset_pix got %0d want 0", pix_o);
    end
    @(posedge pclk); #1;
    s_rst = 1'b0;
    repeat (3) @(negedge pclk);
    total++;
    if (pix_o !== 8'd0 || href_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle got pix=%0d href=%b want 0/0", pix_o, href_o);
    end
  endtask

  task automatic test_startup_gate();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(1, 3, 1'b0, 8'd50, 1'b0, 8'd50, 1'b0, -1, -1, -1);
    for (int r = 0; r < 3; r++) begin
      nb = row_bad(0, r, W, 8'd50, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL gate row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_uniform();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(0, 4, 1'b1, 8'd20, 1'b0, 8'd20, 1'b0, -1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      nb = row_bad(0, r, W, 8'd20, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL uniform row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
    total++;
    if (beats !== 4 * W) begin
      bad++; $display("FAIL uniform_beats got %0d want %0d", beats, 4 * W);
    end
    total++;
    if (sync_bad !== 0) begin
      bad++; $display("FAIL uniform_sync got %0d errors want 0", sync_bad);
    end
  endtask

  task automatic test_vstep();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(1, 4, 1'b1, 8'd50, 1'b0, 8'd50, 1'b0, -1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      nb = row_bad(1, r, W, 8'd50, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL vstep row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_hstep();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(3, 5, 1'b1, 8'd50, 1'b0, 8'd50, 1'b0, -1, -1, -1);
    for (int r = 0; r < 5; r++) begin
      nb = row_bad(3, r, W, 8'd50, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL hstep row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_threshold_strict();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(2, 3, 1'b1, 8'd40, 1'b0, 8'd40, 1'b0, -1, -1, -1);
    nb = row_bad(2, 2, W, 8'd40, 1'b0, fc, fa, fe);
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL thr_eq: %0d px, col %0d got %0d want %0d", nb, fc, fa, fe);
    end
    drive_frame(2, 3, 1'b1, 8'd39, 1'b0, 8'd39, 1'b0, -1, -1, -1);
    nb = row_bad(2, 2, W, 8'd39, 1'b0, fc, fa, fe);
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL thr_below: %0d px, col %0d got %0d want %0d", nb, fc, fa, fe);
    end
  endtask

  task automatic test_frame_latch();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(2, 4, 1'b1, 8'd20, 1'b0, 8'd255, 1'b0, -1, -1, -1);
    for (int r = 2; r < 4; r++) begin
      nb = row_bad(2, r, W, 8'd20, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL latch_mid row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
    drive_frame(1, 3, 1'b1, 8'd255, 1'b0, 8'd255, 1'b0, -1, -1, -1);
    nb = row_bad(1, 2, W, 8'd255, 1'b0, fc, fa, fe);
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL latch_next800: %0d px, col %0d got %0d want %0d", nb, fc, fa, fe);
    end
    drive_frame(2, 3, 1'b1, 8'd255, 1'b0, 8'd255, 1'b0, -1, -1, -1);
    nb = row_bad(2, 2, W, 8'd255, 1'b0, fc, fa, fe);
    total++;
    if (nb !== 0) begin
      bad++; $display("FAIL latch_next40: %0d px, col %0d got %0d want %0d", nb, fc, fa, fe);
    end
  endtask

  task automatic test_passthrough();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(4, 4, 1'b1, 8'd50, 1'b1, 8'd50, 1'b0, -1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      nb = row_bad(4, r, W, 8'd50, 1'b1, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL gray row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int nb, fc; logic [7:0] fa, fe;
    drive_frame(1, 7, 1'b1, 8'd50, 1'b0, 8'd50, 1'b0, -1, 5, 100);
    gate_chk = 1'b0;
    total++;
    if (rst_obs !== 10'd0) begin
      bad++; $display("FAIL rst_outputs got %h want 0", rst_obs);
    end
    total++;
    if (nz_gate !== 0) begin
      bad++; $display("FAIL rst_gate got %0d nonzero px want 0", nz_gate);
    end
    drive_frame(1, 4, 1'b1, 8'd50, 1'b0, 8'd50, 1'b0, -1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      nb = row_bad(1, r, W, 8'd50, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL rst_next row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_short_line();
    int nb, fc, len; logic [7:0] fa, fe;
    drive_frame(1, 4, 1'b1, 8'd50, 1'b0, 8'd50, 1'b0, 1, -1, -1);
    total++;
    if (beats !== 3 * W + 300) begin
      bad++; $display("FAIL short_beats got %0d want %0d", beats, 3 * W + 300);
    end
    for (int r = 0; r < 4; r++) begin
      len = (r == 1) ? 300 : W;
      nb = row_bad(1, r, len, 8'd50, 1'b0, fc, fa, fe);
      total++;
      if (nb !== 0) begin
        bad++; $display("FAIL short row %0d: %0d px, col %0d got %0d want %0d", r, nb, fc, fa, fe);
      end
    end
  endtask

  task automatic test_sync_align();
    total++;
    if (sync_bad !== 0) begin
      bad++; $display("FAIL sync_align got %0d errors want 0", sync_bad);
    end
  endtask

  initial begin
    test_reset();
    test_startup_gate();
    test_uniform();
    test_vstep();
    test_hstep();
    test_threshold_strict();
    test_frame_latch();
    test_passthrough();
    test_reset_mid_frame();
    test_short_line();
    test_sync_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
